// File: rtl/divisor_subtrai_desloca_if.sv
// Start/done/idle handshake and operand/result bundle
// shared by the restoring divider and its driver.
interface divisor_subtrai_desloca_if #(
    parameter int N = 4
);
    logic           st;
    logic [2*N-1:0] dividendo;
    logic [N-1:0]   divisor;
    logic           done;
    logic           idle;
    logic [N-1:0]   quociente;
    logic [N-1:0]   resto;
    logic           estouro;

    modport master (
        output st, dividendo, divisor,
        input  done, idle, quociente, resto, estouro
    );

    modport slave (
        input  st, dividendo, divisor,
        output done, idle, quociente, resto, estouro
    );
endinterface

// File: rtl/divisor_subtrai_desloca.sv
// Restoring shift-subtract unsigned divider: 2N-bit dividend by
// N-bit divisor, one quotient bit per clock, st/done/idle handshake.
module divisor_subtrai_desloca #(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    divisor_subtrai_desloca_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nx;
    logic [2*N:0]   acc, acc_nx, sh;
    logic [N:0]     top, dif;
    logic [N-1:0]   dvs;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   quo_r, rem_r;
    logic           ovf_r;
    logic           ovf;
    logic           last;

    // upper half >= divisor means the quotient cannot fit (also covers /0)
    assign ovf  = bus.dividendo[2*N-1:N] >= bus.divisor;
    assign last = cnt == CW'(1);

    always_comb begin
        sh     = acc << 1;
        top    = sh[2*N:N];
        dif    = top - {1'b0, dvs};
        acc_nx = sh;
        if (top >= {1'b0, dvs}) begin
            acc_nx[2*N:N] = dif;
            acc_nx[0]     = 1'b1;
        end else begin
            acc_nx[0]     = 1'b0;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.st) state_nx = ovf ? DONE : RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            dvs   <= '0;
            quo_r <= '0;
            rem_r <= '0;
            ovf_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.st) begin
                        dvs <= bus.divisor;
                        if (ovf) begin
                            quo_r <= '0;
                            rem_r <= '0;
                            ovf_r <= 1'b1;
                        end else begin
                            acc <= {1'b0, bus.dividendo};
                            cnt <= CW'(N);
                        end
                    end
                end
                RUN: begin
                    acc <= acc_nx;
                    cnt <= cnt - CW'(1);
                    if (last) begin
                        quo_r <= acc_nx[N-1:0];
                        rem_r <= acc_nx[2*N-1:N];
                        ovf_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.idle      = state == IDLE;
    assign bus.done      = state == DONE;
    assign bus.quociente = quo_r;
    assign bus.resto     = rem_r;
    assign bus.estouro   = ovf_r;
endmodule
